// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - board reset holder, push-button debouncer and LED activity stretcher
// Optional BOARD_IO_PWM_EN: adds led_duty input and a free-running 4-bit PWM dimmer on the LEDs.
`timescale 1ns/1ps
module board_io_ctrl #(
  parameter int NUM_SW         = 4,
  parameter int NUM_LED        = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int DEB_CYCLES     = 500000,
  parameter int RST_HOLD       = 1024,
  parameter int STRETCH_CYCLES = 2500000,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ext_rst_n,
  output logic               sys_rst_n,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic [NUM_SW-1:0]  sw_q,
  output logic [NUM_SW-1:0]  sw_rise,
  output logic [NUM_SW-1:0]  sw_fall,
  input  logic [NUM_LED-1:0] act,
  input  logic [NUM_LED-1:0] led_force,
`ifdef BOARD_IO_PWM_EN
  input  logic [3:0]         led_duty,
`endif
  output logic [NUM_LED-1:0] led
);

  localparam int RST_W = $clog2(RST_HOLD + 1);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int STR_W = $clog2(STRETCH_CYCLES + 1);

  localparam logic [RST_W-1:0]   HOLD_LAST = RST_W'(RST_HOLD);
  localparam logic [RST_W-1:0]   HOLD_PRE  = RST_W'(RST_HOLD - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STR_W-1:0]   STR_LOAD  = STR_W'(STRETCH_CYCLES);
  localparam logic [NUM_LED-1:0] LED_OFF   = {NUM_LED{LED_ACTIVE_LOW != 0}};

  // ---------------- reset holder ----------------
  logic [SYNC_STAGES-1:0] ext_sync;
  logic [RST_W-1:0]       hold_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_sync  <= '0;
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
    end else begin
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_rst_n};
      if (!ext_sync[SYNC_STAGES-1]) begin
        hold_cnt  <= '0;
        sys_rst_n <= 1'b0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt  <= hold_cnt + 1'b1;
        // release on the same edge the count lands on RST_HOLD
        sys_rst_n <= (hold_cnt == HOLD_PRE);
      end
    end
  end

  // ---------------- button debouncer ----------------
  logic [NUM_SW-1:0] sw_sync [SYNC_STAGES];
  logic [DEB_W-1:0]  deb_cnt [NUM_SW];
  logic [NUM_SW-1:0] sw_s;

  assign sw_s = sw_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sw_sync[s] <= '0;
      for (int b = 0; b < NUM_SW; b++) deb_cnt[b] <= '0;
      sw_q    <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_sync[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sw_sync[s] <= sw_sync[s-1];
      sw_rise <= '0;
      sw_fall <= '0;
      for (int b = 0; b < NUM_SW; b++) begin
        if (sw_s[b] == sw_q[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_LAST) begin
          deb_cnt[b] <= '0;
          sw_q[b]    <= sw_s[b];
          sw_rise[b] <= sw_s[b];
          sw_fall[b] <= ~sw_s[b];
        end else begin
          deb_cnt[b] <= deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  // ---------------- activity stretchers ----------------
  logic [NUM_LED-1:0] act_sync [SYNC_STAGES];
  logic [NUM_LED-1:0] act_prev;
  logic [STR_W-1:0]   str_cnt [NUM_LED];
  logic [NUM_LED-1:0] act_s;
  logic [NUM_LED-1:0] act_evt;
  logic [NUM_LED-1:0] led_on;

  assign act_s   = act_sync[SYNC_STAGES-1];
  assign act_evt = act_s ^ act_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) act_sync[s] <= '0;
      for (int l = 0; l < NUM_LED; l++) str_cnt[l] <= '0;
      act_prev <= '0;
    end else begin
      act_sync[0] <= act;
      for (int s = 1; s < SYNC_STAGES; s++) act_sync[s] <= act_sync[s-1];
      act_prev <= act_s;
      // an event on the last counted clock reloads, so the LED never blinks off
      for (int l = 0; l < NUM_LED; l++) begin
        if (act_evt[l]) str_cnt[l] <= STR_LOAD;
        else if (str_cnt[l] != '0) str_cnt[l] <= str_cnt[l] - 1'b1;
      end
    end
  end

`ifdef BOARD_IO_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end
`endif

  always_comb begin
    led_on = led_force;
    for (int l = 0; l < NUM_LED; l++) begin
      if (str_cnt[l] != '0) led_on[l] = 1'b1;
    end
`ifdef BOARD_IO_PWM_EN
    if (pwm_cnt >= led_duty) led_on = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) led <= LED_OFF;
    else        led <= led_on ^ LED_OFF;
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - randomized bench for board_io_ctrl against a history-based reference model
`timescale 1ns/1ps
module tb_board_io_ctrl;

  localparam int NUM_SW  = 4;
  localparam int NUM_LED = 8;
  localparam int SYNC    = 2;
  localparam int DEB     = 4;
  localparam int HOLD    = 8;
  localparam int STR     = 5;
  localparam int LOW     = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, ext_rst_n, sys_rst_n;
  logic [NUM_SW-1:0]  sw_raw, sw_q, sw_rise, sw_fall;
  logic [NUM_LED-1:0] act, led_force, led;
`ifdef BOARD_IO_PWM_EN
  logic [3:0]         led_duty;
`endif

  board_io_ctrl #(
    .NUM_SW(NUM_SW), .NUM_LED(NUM_LED), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB),
    .RST_HOLD(HOLD), .STRETCH_CYCLES(STR), .LED_ACTIVE_LOW(LOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ext_rst_n(ext_rst_n), .sys_rst_n(sys_rst_n),
    .sw_raw(sw_raw), .sw_q(sw_q), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .act(act), .led_force(led_force),
`ifdef BOARD_IO_PWM_EN
    .led_duty(led_duty),
`endif
    .led(led)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n, m;

  // input samples taken on every clock since the last reset, index 0 = first released edge
  bit                 ext_h[$];
  logic [NUM_SW-1:0]  sw_h[$];
  logic [NUM_LED-1:0] act_h[$];
  logic [NUM_SW-1:0]  q_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit ext_at(int k);
    if (k < 0 || k >= ext_h.size()) return 1'b0;
    return ext_h[k];
  endfunction

  // synchronised value visible after edge k = raw sample SYNC-1 edges earlier
  function automatic logic [NUM_SW-1:0] sw_s(int k);
    int j = k - SYNC + 1;
    if (j < 0 || j >= sw_h.size()) return '0;
    return sw_h[j];
  endfunction

  function automatic logic [NUM_LED-1:0] act_s(int k);
    int j = k - SYNC + 1;
    if (j < 0 || j >= act_h.size()) return '0;
    return act_h[j];
  endfunction

  task automatic model_check();
    logic               e_sys;
    logic [NUM_SW-1:0]  e_rise, e_fall, v;
    logic [NUM_LED-1:0] e_led, a1, a2;
    bit                 flip, st, on;
    int                 i;
    e_rise = '0;
    e_fall = '0;
    if (!rst_n) begin
      ext_h.delete(); sw_h.delete(); act_h.delete();
      q_m   = '0;
      e_sys = 1'b0;
      e_led = {NUM_LED{LOW == 1}};
    end else begin
      ext_h.push_back(ext_rst_n);
      sw_h.push_back(sw_raw);
      act_h.push_back(act);
      i = ext_h.size() - 1;
      // released once the pin was high on the HOLD samples ending SYNC clocks ago
      e_sys = 1'b1;
      for (int k = i - HOLD - SYNC + 1; k <= i - SYNC; k++)
        if (!ext_at(k)) e_sys = 1'b0;
      for (int b = 0; b < NUM_SW; b++) begin
        flip = 1'b1;
        for (int k = i - DEB; k < i; k++) begin
          v = sw_s(k);
          if (v[b] == q_m[b]) flip = 1'b0;
        end
        if (flip) begin
          q_m[b]    = ~q_m[b];
          e_rise[b] = q_m[b];
          e_fall[b] = ~q_m[b];
        end
      end
      for (int l = 0; l < NUM_LED; l++) begin
        st = 1'b0;
        for (int e = i - STR; e < i; e++) begin
          if (e >= 0) begin
            a1 = act_s(e - 1);
            a2 = act_s(e - 2);
            if (a1[l] != a2[l]) st = 1'b1;
          end
        end
        on = st | led_force[l];
`ifdef BOARD_IO_PWM_EN
        on = on & ((i % 16) < int'(led_duty));
`endif
        e_led[l] = on ^ (LOW == 1);
      end
    end
    check("sys_rst_n", sys_rst_n, e_sys);
    check("sw_q", sw_q, q_m);
    check("sw_rise", sw_rise, e_rise);
    check("sw_fall", sw_fall, e_fall);
    check("led", led, e_led);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_check();
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; ext_rst_n = 1'b0; sw_raw = '0; act = '0; led_force = 8'h81;
`ifdef BOARD_IO_PWM_EN
    led_duty = 4'd15;
`endif
    repeat (3) tick();
    check("reset_led", led, 8'hFF);
    rst_n = 1'b1;
    repeat (3) tick();

    // reset holder release latency
    ext_rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 40);
    check("rst_rise_lat", n, SYNC + HOLD);

    // one-clock glitch restarts the hold
    repeat (10) tick();
    ext_rst_n = 1'b0;
    tick();
    ext_rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (sys_rst_n !== 1'b0 && n < 40);
    check("rst_glitch_drop", n, SYNC);
    do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 80);
    check("rst_glitch_lat", n, SYNC + HOLD);

    // bouncing button settles high
    for (int k = 0; k < 4; k++) begin
      sw_raw[0] = (k % 2 == 0);
      tick();
    end
    sw_raw[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (sw_q[0] !== 1'b1 && n < 40);
    check("sw0_settle_lat", n, SYNC + DEB);
    repeat (4) tick();

    // pulse shorter than the debounce window is ignored
    sw_raw[1] = 1'b1;
    repeat (3) tick();
    sw_raw[1] = 1'b0;
    repeat (10) tick();
    check("sw1_short_pulse", sw_q[1], 1'b0);

`ifndef BOARD_IO_PWM_EN
    // single activity edge: latency and on-time
    led_force = '0;
    repeat (12) tick();
    act[2] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (led[2] !== 1'b0 && n < 20);
    check("act_lat", n, SYNC + 2);
    m = 1;
    while (led[2] === 1'b0 && m < 40) begin
      tick();
      if (led[2] === 1'b0) m++;
    end
    check("act_width", m, STR);
`endif

    // retrigger exactly as the stretch count reaches 1
    led_force = '0;
    repeat (12) tick();
    act[2] = 1'b0;
    repeat (5) tick();
    act[2] = 1'b1;
    repeat (15) tick();

`ifndef BOARD_IO_PWM_EN
    led_force = 8'h81;
    tick();
    check("force_81", led, 8'h7E);
`endif

    // reset mid-stretch and mid-debounce
    led_force = '0;
    act[3]    = 1'b1;
    sw_raw[2] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_led", led, 8'hFF);
    rst_n = 1'b1;
    repeat (12) tick();

`ifdef BOARD_IO_PWM_EN
    act = '0; sw_raw = '0;
    led_force = 8'h01; led_duty = 4'd4;
    repeat (12) tick();
    n = 0;
    for (int k = 0; k < 32; k++) begin tick(); if (led[0] === 1'b0) n++; end
    check("pwm_duty4", n, 8);
    led_duty = 4'd0;
    n = 0;
    for (int k = 0; k < 32; k++) begin tick(); if (led[0] === 1'b0) n++; end
    check("pwm_duty0", n, 0);
`endif

    // randomized traffic, rare resets and reset-pin glitches
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      ext_rst_n = ($urandom_range(0, 49) != 0);
      for (int b = 0; b < NUM_SW; b++)
        if ($urandom_range(0, 5) == 0) sw_raw[b] = ~sw_raw[b];
      for (int l = 0; l < NUM_LED; l++)
        if ($urandom_range(0, 6) == 0) act[l] = ~act[l];
      if ($urandom_range(0, 19) == 0) led_force = NUM_LED'($urandom);
`ifdef BOARD_IO_PWM_EN
      if ($urandom_range(0, 63) == 0) led_duty = 4'($urandom);
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
